multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Parameters: none; all encodings below are fixed.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 op  input  6  IR[31:26]; IR is stable from the cycle after FETCH until the next FETCH.
REQ-005 funct  input  6  IR[5:0].
REQ-006 zero  input  1  ALU zero flag, valid in BR state.
REQ-007 pcwr  output  1  PC write enable.
REQ-008 pcsrc  output  2  PC source: 00 pc+4, 01 branch target, 10 jump target.
REQ-009 irwr  output  1  instruction register write enable.
REQ-010 regwe  output  1  register file write enable; drives the regfile we port.
REQ-011 regdst  output  1  register file write address select: 0 rt, 1 rd.
REQ-012 wbsel  output  2  writeback data select: 00 ALU result, 01 memory data, 10 imm<<16.
REQ-013 alusrc  output  1  ALU B operand select: 0 busB, 1 extended imm.
REQ-014 extop  output  1  immediate extension: 0 zero-extend, 1 sign-extend.
REQ-015 aluop  output  3  000 add, 001 sub, 010 or, 011 decode by funct.
REQ-016 memwr  output  1  data memory write enable.
REQ-017 state  output  3  current state, for debug and bench observation.

Function
REQ-018 Moore FSM, states (encoding): FETCH 000, DCD 001, EXE 010, MRD 011, MWR 100, WB 101, BR 110, JMP 111.
REQ-019 Supported ops: R-type 000000 (addu 100001, subu 100011), ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010.
REQ-020 FETCH -> DCD unconditionally.
REQ-021 In FETCH: irwr=1, pcwr=1, pcsrc=00.
REQ-022 DCD transitions: R-type/ori/lw/sw -> EXE; lui -> WB; beq -> BR; j -> JMP; any other op -> FETCH.
REQ-023 DCD with an unsupported op: no write enables asserted.
REQ-024 R-type with unsupported funct: executes as a no-op, with regwe held 0 in WB.
REQ-025 EXE transitions: lw -> MRD, sw -> MWR, otherwise -> WB.
REQ-026 EXE outputs: alusrc=1 except R-type; extop=1 for lw/sw, 0 for ori; aluop 011 for R-type, 010 for ori, 000 for lw/sw.
REQ-027 MRD -> WB.
REQ-028 MWR: memwr=1 for exactly one cycle, then -> FETCH.
REQ-029 WB: regwe=1 for exactly one cycle, then -> FETCH.
REQ-030 WB selects: regdst=1 only for R-type; wbsel=01 for lw, 10 for lui, 00 otherwise.
REQ-031 BR: aluop=001, alusrc=0, pcsrc=01, pcwr=zero; then -> FETCH.
REQ-032 JMP: pcwr=1, pcsrc=10; then -> FETCH.
REQ-033 Latency in cycles, FETCH inclusive: R-type/ori 4, lw 5, sw 4, lui 3, beq 3, j 3.
REQ-034 Outside the states named above, pcwr/irwr/regwe/memwr SHALL be 0; at most one of regwe/memwr is asserted in any cycle.
REQ-035 Selects (pcsrc, regdst, wbsel, alusrc, extop, aluop) SHALL hold 0 in states where they are not specified.

Reset
REQ-036 While rst=1, all outputs SHALL be 0, including state.
REQ-037 On the first rising edge with rst=0 sampled after reset, the FSM SHALL be in FETCH.
REQ-038 rst asserted mid-instruction (e.g. in MWR or WB) SHALL suppress that cycle's memwr/regwe, and the instruction SHALL be abandoned.

Verification
REQ-039 rst=1 for 2 cycles, op=000000 -> all outputs 0, then state 000 with pcwr=1, irwr=1.
REQ-040 addu (op 000000, funct 100001) -> states 000,001,010,101; regwe=1 with regdst=1, wbsel=00 in cycle 4 only.
REQ-041 lw (op 100011) -> 000,001,010,011,101; extop=1, aluop=000 in EXE; wbsel=01, regwe=1 in WB.
REQ-042 beq (op 000100) twice, zero=1 then zero=0 -> in BR pcwr=1, pcsrc=01 the first time; pcwr=0 the second time; no regwe/memwr either time.
REQ-043 sw (op 101011) with rst=1 in the MWR cycle -> memwr stays 0, state 000 after release.
REQ-044 op=111111 -> 000,001,000; no pcwr after FETCH, no regwe, no memwr.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: Moore FSM with registered control outputs.
// Outputs are forced low while rst is high, so a reset mid-instruction also cancels that cycle's writes.
module multi_cycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcwr,
    output logic [1:0] pcsrc,
    output logic       irwr,
    output logic       regwe,
    output logic       regdst,
    output logic [1:0] wbsel,
    output logic       alusrc,
    output logic       extop,
    output logic [2:0] aluop,
    output logic       memwr,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        FETCH = 3'b000,
        DCD   = 3'b001,
        EXE   = 3'b010,
        MRD   = 3'b011,
        MWR   = 3'b100,
        WB    = 3'b101,
        BR    = 3'b110,
        JMP   = 3'b111
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JMP  = 2'b10;
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LUI  = 2'b10;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_FN  = 3'b011;

    logic is_rtype, is_ori, is_lw, is_sw, is_beq, is_lui, is_j, funct_ok;

    assign is_rtype = (op == OP_RTYPE);
    assign is_ori   = (op == OP_ORI);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_lui   = (op == OP_LUI);
    assign is_j     = (op == OP_J);
    assign funct_ok = (funct == FN_ADDU) || (funct == FN_SUBU);

    state_t     state_reg, state_next;
    logic       pcwr_reg, pcwr_next;
    logic [1:0] pcsrc_reg, pcsrc_next;
    logic       irwr_reg, irwr_next;
    logic       regwe_reg, regwe_next;
    logic       regdst_reg, regdst_next;
    logic [1:0] wbsel_reg, wbsel_next;
    logic       alusrc_reg, alusrc_next;
    logic       extop_reg, extop_next;
    logic [2:0] aluop_reg, aluop_next;
    logic       memwr_reg, memwr_next;
    logic       br_reg, br_next;

    always_comb begin
        state_next = FETCH;
        case (state_reg)
            FETCH: state_next = DCD;
            DCD: begin
                if (is_rtype || is_ori || is_lw || is_sw)
                    state_next = EXE;
                else if (is_lui)
                    state_next = WB;
                else if (is_beq)
                    state_next = BR;
                else if (is_j)
                    state_next = JMP;
                else
                    state_next = FETCH;
            end
            EXE: begin
                if (is_lw)
                    state_next = MRD;
                else if (is_sw)
                    state_next = MWR;
                else
                    state_next = WB;
            end
            MRD:     state_next = WB;
            default: state_next = FETCH;
        endcase
    end

    // Outputs are decoded from the state being entered, so they are valid from the first cycle of that state.
    always_comb begin
        pcwr_next   = 1'b0;
        pcsrc_next  = PC_SEQ;
        irwr_next   = 1'b0;
        regwe_next  = 1'b0;
        regdst_next = 1'b0;
        wbsel_next  = WB_ALU;
        alusrc_next = 1'b0;
        extop_next  = 1'b0;
        aluop_next  = ALU_ADD;
        memwr_next  = 1'b0;
        br_next     = 1'b0;
        case (state_next)
            FETCH: begin
                irwr_next = 1'b1;
                pcwr_next = 1'b1;
            end
            EXE: begin
                alusrc_next = !is_rtype;
                extop_next  = is_lw || is_sw;
                if (is_rtype)
                    aluop_next = ALU_FN;
                else if (is_ori)
                    aluop_next = ALU_OR;
                else
                    aluop_next = ALU_ADD;
            end
            MWR: memwr_next = 1'b1;
            WB: begin
                regwe_next  = !is_rtype || funct_ok;
                regdst_next = is_rtype;
                if (is_lw)
                    wbsel_next = WB_MEM;
                else if (is_lui)
                    wbsel_next = WB_LUI;
                else
                    wbsel_next = WB_ALU;
            end
            BR: begin
                aluop_next = ALU_SUB;
                pcsrc_next = PC_BR;
                br_next    = 1'b1;
            end
            JMP: begin
                pcwr_next  = 1'b1;
                pcsrc_next = PC_JMP;
            end
            default: ;
        endcase
    end

    // Reset parks the FSM in FETCH with FETCH's outputs preloaded; the output mask hides them until release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= FETCH;
            pcwr_reg   <= 1'b1;
            pcsrc_reg  <= PC_SEQ;
            irwr_reg   <= 1'b1;
            regwe_reg  <= 1'b0;
            regdst_reg <= 1'b0;
            wbsel_reg  <= WB_ALU;
            alusrc_reg <= 1'b0;
            extop_reg  <= 1'b0;
            aluop_reg  <= ALU_ADD;
            memwr_reg  <= 1'b0;
            br_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pcwr_reg   <= pcwr_next;
            pcsrc_reg  <= pcsrc_next;
            irwr_reg   <= irwr_next;
            regwe_reg  <= regwe_next;
            regdst_reg <= regdst_next;
            wbsel_reg  <= wbsel_next;
            alusrc_reg <= alusrc_next;
            extop_reg  <= extop_next;
            aluop_reg  <= aluop_next;
            memwr_reg  <= memwr_next;
            br_reg     <= br_next;
        end
    end

    // The branch decision uses zero as it is during BR, so it cannot be registered ahead of time.
    assign pcwr   = !rst && (pcwr_reg || (br_reg && zero));
    assign pcsrc  = rst ? 2'b00 : pcsrc_reg;
    assign irwr   = !rst && irwr_reg;
    assign regwe  = !rst && regwe_reg;
    assign regdst = !rst && regdst_reg;
    assign wbsel  = rst ? 2'b00 : wbsel_reg;
    assign alusrc = !rst && alusrc_reg;
    assign extop  = !rst && extop_reg;
    assign aluop  = rst ? 3'b000 : aluop_reg;
    assign memwr  = !rst && memwr_reg;
    assign state  = rst ? 3'b000 : state_reg;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: expected per-cycle output vectors are queued per instruction
// and compared one cycle at a time.
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcwr, irwr, regwe, regdst, alusrc, extop, memwr;
    logic [1:0] pcsrc, wbsel;
    logic [2:0] aluop, state;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [16:0] vec;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .pcwr(pcwr), .pcsrc(pcsrc), .irwr(irwr), .regwe(regwe), .regdst(regdst),
        .wbsel(wbsel), .alusrc(alusrc), .extop(extop), .aluop(aluop), .memwr(memwr),
        .state(state)
    );

    // Vector layout: state, pcwr, pcsrc, irwr, regwe, regdst, wbsel, alusrc, extop, aluop, memwr
    logic [16:0] obs;
    assign obs = {state, pcwr, pcsrc, irwr, regwe, regdst, wbsel, alusrc, extop, aluop, memwr};

    function automatic logic [16:0] mk(input logic [2:0] st, input logic pw, input logic [1:0] ps,
                                       input logic iw, input logic rw, input logic rd,
                                       input logic [1:0] ws, input logic as, input logic ex,
                                       input logic [2:0] ao, input logic mw);
        return {st, pw, ps, iw, rw, rd, ws, as, ex, ao, mw};
    endfunction

    task automatic push(input string tag, input logic [16:0] v);
        exp_t e;
        e.tag = tag;
        e.vec = v;
        sb.push_back(e);
    endtask

    // Compare the current cycle against the oldest expectation, then advance to the next cycle.
    task automatic sample();
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty: got %h required an expectation", obs);
        end else begin
            e = sb.pop_front();
            checks++;
            assert (obs === e.vec) else begin
                errors++;
                $error("FAIL %s: got %h required %h", e.tag, obs, e.vec);
            end
            $display("check %s: obs=%h exp=%h", e.tag, obs, e.vec);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        while (sb.size() > 0) sample();
    endtask

    task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic z);
        op    = o;
        funct = f;
        zero  = z;
    endtask

    task automatic push_fetch_dcd(input string name);
        push({name, "_fetch"}, mk(3'b000, 1, 2'b00, 1, 0, 0, 2'b00, 0, 0, 3'b000, 0));
        push({name, "_dcd"},   mk(3'b001, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 3'b000, 0));
    endtask

    logic [16:0] all_zero;

    initial begin
        all_zero = '0;
        rst   = 1'b1;
        op    = 6'b000000;
        funct = 6'b000000;
        zero  = 1'b0;
        @(posedge clk);
        #1;

        push("reset_c1", all_zero);
        push("reset_c2", all_zero);
        drain();
        rst = 1'b0;

        // addu
        instr(6'b000000, 6'b100001, 1'b0);
        push_fetch_dcd("addu");
        push("addu_exe", mk(3'b010, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 3'b011, 0));
        push("addu_wb",  mk(3'b101, 0, 2'b00, 0, 1, 1, 2'b00, 0, 0, 3'b000, 0));
        drain();

        // lw
        instr(6'b100011, 6'b000000, 1'b0);
        push_fetch_dcd("lw");
        push("lw_exe", mk(3'b010, 0, 2'b00, 0, 0, 0, 2'b00, 1, 1, 3'b000, 0));
        push("lw_mrd", mk(3'b011, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 3'b000, 0));
        push("lw_wb",  mk(3'b101, 0, 2'b00, 0, 1, 0, 2'b01, 0, 0, 3'b000, 0));
        drain();

        // beq taken then not taken
        instr(6'b000100, 6'b000000, 1'b1);
        push_fetch_dcd("beq1");
        push("beq1_br", mk(3'b110, 1, 2'b01, 0, 0, 0, 2'b00, 0, 0, 3'b001, 0));
        drain();
        instr(6'b000100, 6'b000000, 1'b0);
        push_fetch_dcd("beq0");
        push("beq0_br", mk(3'b110, 0, 2'b01, 0, 0, 0, 2'b00, 0, 0, 3'b001, 0));
        drain();

        // sw completing normally
        instr(6'b101011, 6'b000000, 1'b0);
        push_fetch_dcd("sw");
        push("sw_exe", mk(3'b010, 0, 2'b00, 0, 0, 0, 2'b00, 1, 1, 3'b000, 0));
        push("sw_mwr", mk(3'b100, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 3'b000, 1));
        drain();

        // sw with reset landing on its MWR cycle
        instr(6'b101011, 6'b000000, 1'b0);
        push_fetch_dcd("swrst");
        push("swrst_exe", mk(3'b010, 0, 2'b00, 0, 0, 0, 2'b00, 1, 1, 3'b000, 0));
        drain();
        rst = 1'b1;
        push("swrst_mwr", all_zero);
        drain();
        rst = 1'b0;

        // unsupported op returns to FETCH after DCD
        instr(6'b111111, 6'b000000, 1'b0);
        push_fetch_dcd("badop");
        drain();

        // ori
        instr(6'b001101, 6'b000000, 1'b0);
        push_fetch_dcd("ori");
        push("ori_exe", mk(3'b010, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 3'b010, 0));
        push("ori_wb",  mk(3'b101, 0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 3'b000, 0));
        drain();

        // lui
        instr(6'b001111, 6'b000000, 1'b0);
        push_fetch_dcd("lui");
        push("lui_wb", mk(3'b101, 0, 2'b00, 0, 1, 0, 2'b10, 0, 0, 3'b000, 0));
        drain();

        // j
        instr(6'b000010, 6'b000000, 1'b0);
        push_fetch_dcd("j");
        push("j_jmp", mk(3'b111, 1, 2'b10, 0, 0, 0, 2'b00, 0, 0, 3'b000, 0));
        drain();

        // subu
        instr(6'b000000, 6'b100011, 1'b0);
        push_fetch_dcd("subu");
        push("subu_exe", mk(3'b010, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 3'b011, 0));
        push("subu_wb",  mk(3'b101, 0, 2'b00, 0, 1, 1, 2'b00, 0, 0, 3'b000, 0));
        drain();

        // R-type with unsupported funct: walks EXE/WB but never writes
        instr(6'b000000, 6'b101010, 1'b0);
        push_fetch_dcd("badfn");
        push("badfn_exe", mk(3'b010, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 3'b011, 0));
        push("badfn_wb",  mk(3'b101, 0, 2'b00, 0, 0, 1, 2'b00, 0, 0, 3'b000, 0));
        drain();

        // addu with reset landing on its WB cycle
        instr(6'b000000, 6'b100001, 1'b0);
        push_fetch_dcd("wbrst");
        push("wbrst_exe", mk(3'b010, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 3'b011, 0));
        drain();
        rst = 1'b1;
        push("wbrst_wb", all_zero);
        drain();
        rst = 1'b0;
        instr(6'b000010, 6'b000000, 1'b0);
        push_fetch_dcd("post");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
